uart_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single bus slave port of the UART controller among NUM_MASTERS requesters.

---
 rtl/uart_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter that lets several bus masters share the UART register port.
// It runs one transaction at a time and uses a WAIT-state timeout to recover from a hung slave.
module uart_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            i_req,
  input  logic [NUM_MASTERS-1:0]            i_rnw,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_wdata,
  output logic [NUM_MASTERS-1:0]            o_gnt,
  output logic [NUM_MASTERS-1:0]            o_done,
  output logic                              o_err,
  output logic [DATA_WIDTH-1:0]             o_rdata,
  output logic                              o_bus_en,
  output logic                              o_bus_rnw,
  output logic [ADDR_WIDTH-1:0]             o_bus_addr,
  output logic [DATA_WIDTH-1:0]             o_bus_wdata,
  input  logic                              i_bus_rdy,
  input  logic [DATA_WIDTH-1:0]             i_bus_rdata
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_idx;
  logic                  r_rnw;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [CW-1:0]         r_cnt;

  logic                  w_found;
  logic [IW-1:0]         w_pick;
  logic                  w_timeout;

  // Scan from the master after the last winner, so the last winner has the lowest priority.
  always_comb begin : arb_scan
    int j;
    w_found = 1'b0;
    w_pick  = '0;
    j       = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!w_found && i_req[j]) begin
        w_found = 1'b1;
        w_pick  = IW'(j);
      end
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(NUM_MASTERS - 1);
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (i_bus_rdy) begin
            r_err <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_RESP:  r_ptr <= r_idx;
        default: ;
      endcase
    end
  end

  // Transaction payload; the outputs are gated by state, so these registers need no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_found) begin
      r_idx   <= w_pick;
      r_rnw   <= i_rnw[w_pick];
      r_addr  <= i_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata <= i_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
    end
    if (r_state == S_WAIT) begin
      if (i_bus_rdy)      r_rdata <= r_rnw ? i_bus_rdata : '0;
      else if (w_timeout) r_rdata <= '0;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_gnt       = '0;
    o_done      = '0;
    o_err       = 1'b0;
    o_rdata     = '0;
    o_bus_en    = 1'b0;
    o_bus_rnw   = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    if (r_state != S_IDLE) begin
      o_gnt       = NUM_MASTERS'(1) << r_idx;
      o_bus_rnw   = r_rnw;
      o_bus_addr  = r_addr;
      o_bus_wdata = r_wdata;
    end
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: begin
        o_bus_en = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT:  if (i_bus_rdy || w_timeout) w_next = S_RESP;
      S_RESP: begin
        o_done  = NUM_MASTERS'(1) << r_idx;
        o_err   = r_err;
        o_rdata = r_rdata;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: latency, round-robin order, timeout, write hold, reset.
module tb_uart_bus_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM-1:0]    i_req = '0;
  logic [NM-1:0]    i_rnw = '0;
  logic [NM*AW-1:0] i_addr = '0;
  logic [NM*DW-1:0] i_wdata = '0;
  logic [NM-1:0]    o_gnt;
  logic [NM-1:0]    o_done;
  logic             o_err;
  logic [DW-1:0]    o_rdata;
  logic             o_bus_en;
  logic             o_bus_rnw;
  logic [AW-1:0]    o_bus_addr;
  logic [DW-1:0]    o_bus_wdata;
  logic             i_bus_rdy = 1'b0;
  logic [DW-1:0]    i_bus_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_rnw(i_rnw), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_bus_en(o_bus_en), .o_bus_rnw(o_bus_rnw),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .i_bus_rdy(i_bus_rdy),
    .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(o_gnt), 32'h0);
    check({tag, "_done"}, 32'(o_done), 32'h0);
    check({tag, "_en"}, 32'(o_bus_en), 32'h0);
    check({tag, "_addr"}, o_bus_addr, 32'h0);
    check({tag, "_wdata"}, o_bus_wdata, 32'h0);
    check({tag, "_rdata"}, o_rdata, 32'h0);
  endtask

  // Called in an IDLE cycle with requests set; runs a zero-wait read for master m.
  task automatic xact(input int m, input logic [31:0] slave_data, input logic [31:0] exp_rdata);
    tick();
    check($sformatf("issue_gnt_m%0d", m), 32'(o_gnt), 32'(1 << m));
    check($sformatf("issue_en_m%0d", m), 32'(o_bus_en), 32'h1);
    tick();
    check($sformatf("wait_en_m%0d", m), 32'(o_bus_en), 32'h0);
    check($sformatf("wait_done_m%0d", m), 32'(o_done), 32'h0);
    i_bus_rdy   = 1'b1;
    i_bus_rdata = slave_data;
    tick();
    i_bus_rdy   = 1'b0;
    i_bus_rdata = '0;
    check($sformatf("resp_done_m%0d", m), 32'(o_done), 32'(1 << m));
    check($sformatf("resp_rdata_m%0d", m), o_rdata, exp_rdata);
    check($sformatf("resp_err_m%0d", m), 32'(o_err), 32'h0);
    tick();
    check($sformatf("idle_gnt_m%0d", m), 32'(o_gnt), 32'h0);
    check($sformatf("idle_done_m%0d", m), 32'(o_done), 32'h0);
  endtask

  initial begin
    // 1: reset state and single read from master 0
    tick(); tick();
    rst = 1'b0;
    check_quiet("reset");
    i_rnw = 4'b1111;
    for (int i = 0; i < NM; i++) begin
      i_addr[i*AW +: AW]  = 32'hC000_0000 + 32'(4 * i);
      i_wdata[i*DW +: DW] = 32'h0;
    end
    i_addr[0 +: AW] = 32'hC000_0004;
    i_req = 4'b0001;
    tick();
    check("t1_addr", o_bus_addr, 32'hC000_0004);
    check("t1_rnw", 32'(o_bus_rnw), 32'h1);
    check("t1_en", 32'(o_bus_en), 32'h1);
    tick();
    check("t1_wait_addr", o_bus_addr, 32'hC000_0004);
    i_bus_rdy = 1'b1; i_bus_rdata = 32'h41;
    tick();
    i_bus_rdy = 1'b0; i_bus_rdata = '0;
    i_req = 4'b0000;
    check("t1_done", 32'(o_done), 32'h1);
    check("t1_rdata", o_rdata, 32'h41);
    check("t1_err", 32'(o_err), 32'h0);
    tick();
    check_quiet("t1_idle");

    // 2: all masters requesting after reset -> 0,1,2,3,0
    rst = 1'b1; tick(); rst = 1'b0;
    i_req = 4'b1111;
    xact(0, 32'h100, 32'h100);
    xact(1, 32'h101, 32'h101);
    xact(2, 32'h102, 32'h102);
    xact(3, 32'h103, 32'h103);
    xact(0, 32'h104, 32'h104);

    // 3: after master 2, requests 0101 -> 0 then 2
    i_req = 4'b0100;
    xact(2, 32'h200, 32'h200);
    i_req = 4'b0101;
    xact(0, 32'h201, 32'h201);
    xact(2, 32'h202, 32'h202);
    i_req = 4'b0000;

    // 4: master 1 read, slave silent -> timeout after 8 WAIT cycles
    i_req = 4'b0010;
    tick();
    check("t4_gnt", 32'(o_gnt), 32'h2);
    for (int c = 0; c < TO; c++) begin
      tick();
      check($sformatf("t4_wait%0d_done", c), 32'(o_done), 32'h0);
      check($sformatf("t4_wait%0d_gnt", c), 32'(o_gnt), 32'h2);
    end
    tick();
    i_req = 4'b0000;
    check("t4_done", 32'(o_done), 32'h2);
    check("t4_err", 32'(o_err), 32'h1);
    check("t4_rdata", o_rdata, 32'h0);
    i_bus_rdy = 1'b1; i_bus_rdata = 32'hDEAD;
    tick();
    check_quiet("t4_late1");
    check("t4_late1_err", 32'(o_err), 32'h0);
    tick();
    i_bus_rdy = 1'b0; i_bus_rdata = '0;
    check_quiet("t4_late2");

    // 5: write from master 1 that drops its request while waiting
    i_rnw[1] = 1'b0;
    i_addr[1*AW +: AW]  = 32'hC000_0000;
    i_wdata[1*DW +: DW] = 32'h55;
    i_req = 4'b0010;
    tick();
    check("t5_rnw", 32'(o_bus_rnw), 32'h0);
    check("t5_wdata_issue", o_bus_wdata, 32'h55);
    check("t5_addr", o_bus_addr, 32'hC000_0000);
    tick();
    i_req = 4'b0000;
    i_wdata[1*DW +: DW] = 32'hAA;
    tick();
    check("t5_wdata_wait", o_bus_wdata, 32'h55);
    i_bus_rdy = 1'b1; i_bus_rdata = 32'h77;
    tick();
    i_bus_rdy = 1'b0; i_bus_rdata = '0;
    check("t5_done", 32'(o_done), 32'h2);
    check("t5_rdata", o_rdata, 32'h0);
    check("t5_err", 32'(o_err), 32'h0);
    tick();
    i_rnw[1] = 1'b1;

    // 6: reset during WAIT, then pointer is back at NUM_MASTERS-1
    i_req = 4'b0001;
    tick();
    check("t6_gnt", 32'(o_gnt), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    check_quiet("t6_rst");
    rst = 1'b0;
    i_req = 4'b1001;
    xact(0, 32'h300, 32'h300);
    i_req = 4'b1000;
    xact(3, 32'h301, 32'h301);
    i_req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end
endmodule
